// File: rtl/dispatch.sv
// Block dispatcher: splits a kernel into fixed-size thread blocks,
// assigns them to free cores and reports kernel completion.
module dispatch #(
    parameter int NUM_CORES         = 2,
    parameter int THREADS_PER_BLOCK = 4,
    parameter int TC_BITS           = 8,
    parameter int CT_BITS           = $clog2(THREADS_PER_BLOCK) + 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [TC_BITS-1:0]             thread_count,
    output logic [NUM_CORES-1:0]           core_start,
    output logic [NUM_CORES-1:0]           core_reset,
    output logic [NUM_CORES*TC_BITS-1:0]   core_block_id,
    output logic [NUM_CORES*CT_BITS-1:0]   core_thread_count,
    input  logic [NUM_CORES-1:0]           core_done,
    output logic                           done
);

    localparam int LOG2 = $clog2(THREADS_PER_BLOCK);
    localparam int TW   = TC_BITS + 1;

    typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_DONE} top_e;
    typedef enum logic [1:0] {C_FREE, C_BUSY, C_CLEAN} core_e;

    top_e               top_q, top_d;
    core_e              cst_q [NUM_CORES];
    core_e              cst_d [NUM_CORES];
    logic [TC_BITS-1:0] bid_q [NUM_CORES];
    logic [TC_BITS-1:0] bid_d [NUM_CORES];
    logic [CT_BITS-1:0] ct_q  [NUM_CORES];
    logic [CT_BITS-1:0] ct_d  [NUM_CORES];
    logic [TC_BITS-1:0] tc_q, tc_d;
    logic [TC_BITS-1:0] total_q, total_d;
    logic [TC_BITS-1:0] disp_q, disp_d;
    logic [TC_BITS-1:0] bdone_q, bdone_d;

    logic [TW-1:0]      blk_sum;
    logic [TW-1:0]      rem;
    logic [CT_BITS-1:0] next_ct;
    logic [TC_BITS-1:0] new_total;
    logic               assigned;
    logic               any_clean;

    // Block count rounds up one extra bit wide so 2^TC_BITS-1 threads cannot wrap.
    assign blk_sum   = {1'b0, thread_count} + TW'(THREADS_PER_BLOCK - 1);
    assign new_total = TC_BITS'(blk_sum >> LOG2);
    assign rem       = {1'b0, tc_q} - ({1'b0, disp_q} << LOG2);
    assign next_ct   = (rem >= TW'(THREADS_PER_BLOCK))
                     ? CT_BITS'(THREADS_PER_BLOCK) : CT_BITS'(rem);

    // Next-state logic for the top FSM, per-core FSMs and block counters.
    always_comb begin
        top_d     = top_q;
        tc_d      = tc_q;
        total_d   = total_q;
        disp_d    = disp_q;
        bdone_d   = bdone_q;
        cst_d     = cst_q;
        bid_d     = bid_q;
        ct_d      = ct_q;
        assigned  = 1'b0;
        any_clean = 1'b0;

        for (int i = 0; i < NUM_CORES; i++) begin
            if (cst_q[i] == C_CLEAN) any_clean = 1'b1;
        end

        for (int i = 0; i < NUM_CORES; i++) begin
            unique case (cst_q[i])
                C_FREE: begin
                    if (top_q == S_DISPATCH && !assigned && disp_q < total_q) begin
                        cst_d[i] = C_BUSY;
                        bid_d[i] = disp_q;
                        ct_d[i]  = next_ct;
                        assigned = 1'b1;
                    end
                end
                C_BUSY: begin
                    if (core_done[i]) begin
                        cst_d[i] = C_CLEAN;
                        bdone_d  = bdone_d + TC_BITS'(1);
                    end
                end
                C_CLEAN: cst_d[i] = C_FREE;
                default: cst_d[i] = C_FREE;
            endcase
        end

        if (assigned) disp_d = disp_q + TC_BITS'(1);

        unique case (top_q)
            S_IDLE: begin
                if (start) begin
                    tc_d    = thread_count;
                    total_d = new_total;
                    disp_d  = '0;
                    bdone_d = '0;
                    top_d   = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                if (bdone_q == total_q && !any_clean) top_d = S_DONE;
            end
            S_DONE: begin
                if (!start) top_d = S_IDLE;
            end
            default: top_d = S_IDLE;
        endcase
    end

    // State registers; reset returns every core to FREE immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            top_q   <= S_IDLE;
            tc_q    <= '0;
            total_q <= '0;
            disp_q  <= '0;
            bdone_q <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                cst_q[i] <= C_FREE;
                bid_q[i] <= '0;
                ct_q[i]  <= '0;
            end
        end else begin
            top_q   <= top_d;
            tc_q    <= tc_d;
            total_q <= total_d;
            disp_q  <= disp_d;
            bdone_q <= bdone_d;
            for (int i = 0; i < NUM_CORES; i++) begin
                cst_q[i] <= cst_d[i];
                bid_q[i] <= bid_d[i];
                ct_q[i]  <= ct_d[i];
            end
        end
    end

    // Outputs decode straight from registered state.
    always_comb begin
        done = (top_q == S_DONE);
        for (int i = 0; i < NUM_CORES; i++) begin
            core_start[i]                        = (cst_q[i] == C_BUSY);
            core_reset[i]                        = (cst_q[i] == C_CLEAN);
            core_block_id[i*TC_BITS +: TC_BITS]  = bid_q[i];
            core_thread_count[i*CT_BITS +: CT_BITS] = ct_q[i];
        end
    end

endmodule

// File: tb/tb_dispatch.sv
// Testbench for dispatch: directed latency/corner sequences plus
// a table of kernels checked against a block scoreboard.
module tb_dispatch;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  thread_count;
    logic [1:0]  core_start;
    logic [1:0]  core_reset;
    logic [15:0] core_block_id;
    logic [5:0]  core_thread_count;
    logic [1:0]  core_done;
    logic        done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int tc;
        int nblk;
        int last_tc;
    } vec_t;

    typedef struct {
        int bid;
        int tc;
    } blk_t;

    blk_t exp_q[$];
    vec_t vecs[8];

    dispatch dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .thread_count     (thread_count),
        .core_start       (core_start),
        .core_reset       (core_reset),
        .core_block_id    (core_block_id),
        .core_thread_count(core_thread_count),
        .core_done        (core_done),
        .done             (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [1:0] prev_st;
        logic [1:0] drv;
        int         wait_c [2];
        int         busy_c [2];
        int         seen;
        int         last;
        bit         got_done;
        blk_t       e;
        int         r;
        seen     = 0;
        last     = 0;
        got_done = 0;
        prev_st  = 2'b00;
        drv      = 2'b00;
        busy_c   = '{0, 0};
        wait_c   = '{0, 0};
        exp_q.delete();
        for (int b = 0; b * 4 < v.tc; b++) begin
            r = v.tc - b * 4;
            e.bid = b;
            e.tc  = (r > 4) ? 4 : r;
            exp_q.push_back(e);
        end
        thread_count = 8'(v.tc);
        start        = 1'b1;
        core_done    = 2'b00;
        for (int cyc = 0; cyc < 3000 && !got_done; cyc++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("tc%0d core_reset[%0d]", v.tc, i),
                    int'(core_reset[i]), int'(drv[i]));
                if (core_start[i] && !prev_st[i]) begin
                    if (exp_q.size() == 0) begin
                        chk($sformatf("tc%0d extra block", v.tc), 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("tc%0d block_id", v.tc),
                            int'(core_block_id[i*8 +: 8]), e.bid);
                        chk($sformatf("tc%0d block_tc", v.tc),
                            int'(core_thread_count[i*3 +: 3]), e.tc);
                        last = e.tc;
                    end
                    seen++;
                    busy_c[i] = 0;
                    wait_c[i] = int'($urandom_range(0, 3));
                end
                prev_st[i] = core_start[i];
                drv[i] = core_start[i] && (busy_c[i] >= wait_c[i]);
                busy_c[i]++;
            end
            core_done = drv;
            if (done) begin
                got_done = 1;
                chk($sformatf("tc%0d start at done", v.tc), int'(core_start), 0);
            end
        end
        chk($sformatf("tc%0d done seen", v.tc), int'(got_done), 1);
        chk($sformatf("tc%0d blocks", v.tc), seen, v.nblk);
        chk($sformatf("tc%0d last tc", v.tc), last, v.last_tc);
        chk($sformatf("tc%0d queue left", v.tc), exp_q.size(), 0);
        start     = 1'b0;
        core_done = 2'b00;
        step();
        chk($sformatf("tc%0d done drop", v.tc), int'(done), 0);
    endtask

    initial begin
        vecs = '{
            '{8,   2,  4},
            '{10,  3,  2},
            '{0,   0,  0},
            '{1,   1,  1},
            '{5,   2,  1},
            '{4,   1,  4},
            '{13,  4,  1},
            '{255, 64, 3}
        };

        reset        = 1'b0;
        start        = 1'b0;
        thread_count = 8'd0;
        core_done    = 2'b00;
        #12;
        chk("rst core_start", int'(core_start), 0);
        chk("rst core_reset", int'(core_reset), 0);
        chk("rst block_id", int'(core_block_id), 0);
        chk("rst thread_cnt", int'(core_thread_count), 0);
        chk("rst done", int'(done), 0);
        reset = 1'b1;
        step();

        // Two full blocks, exact assignment latency and cleanup pulses.
        thread_count = 8'd8;
        start        = 1'b1;
        step();
        chk("t8 E start", int'(core_start), 0);
        step();
        chk("t8 E+1 start", int'(core_start), 1);
        chk("t8 c0 bid", int'(core_block_id[7:0]), 0);
        chk("t8 c0 tc", int'(core_thread_count[2:0]), 4);
        step();
        chk("t8 E+2 start", int'(core_start), 3);
        chk("t8 c1 bid", int'(core_block_id[15:8]), 1);
        chk("t8 c1 tc", int'(core_thread_count[5:3]), 4);
        core_done = 2'b01;
        step();
        chk("t8 c0 clean rst", int'(core_reset), 1);
        chk("t8 c0 clean start", int'(core_start), 2);
        core_done = 2'b00;
        step();
        chk("t8 c0 rst pulse", int'(core_reset), 0);
        core_done = 2'b10;
        step();
        chk("t8 c1 clean rst", int'(core_reset), 2);
        core_done = 2'b00;
        step();
        chk("t8 done early", int'(done), 0);
        step();
        chk("t8 done", int'(done), 1);
        step(2);
        chk("t8 done held", int'(done), 1);
        start = 1'b0;
        step();
        chk("t8 done drop", int'(done), 0);

        // Empty kernel.
        thread_count = 8'd0;
        start        = 1'b1;
        step();
        chk("t0 done E", int'(done), 0);
        step();
        chk("t0 done E+1", int'(done), 1);
        chk("t0 no start", int'(core_start), 0);
        start = 1'b0;
        step();
        chk("t0 done drop", int'(done), 0);

        // Asynchronous reset with both cores busy.
        thread_count = 8'd8;
        start        = 1'b1;
        step(3);
        chk("ar busy", int'(core_start), 3);
        #2;
        reset = 1'b0;
        #1;
        chk("ar start", int'(core_start), 0);
        chk("ar block_id", int'(core_block_id), 0);
        chk("ar thread_cnt", int'(core_thread_count), 0);
        start = 1'b0;
        #10;
        reset = 1'b1;
        step(2);
        chk("ar idle start", int'(core_start), 0);
        chk("ar idle done", int'(done), 0);
        thread_count = 8'd4;
        start        = 1'b1;
        step(2);
        chk("ar redo start", int'(core_start), 1);
        chk("ar redo bid", int'(core_block_id[7:0]), 0);
        chk("ar redo tc", int'(core_thread_count[2:0]), 4);

        // Spurious done on a free core must be ignored.
        core_done = 2'b10;
        step();
        chk("sp start", int'(core_start), 1);
        chk("sp reset", int'(core_reset), 0);
        core_done = 2'b00;
        step(2);
        chk("sp no done", int'(done), 0);
        core_done = 2'b01;
        step();
        chk("sp c0 clean", int'(core_reset), 1);
        core_done = 2'b00;
        step(2);
        chk("sp done", int'(done), 1);
        start = 1'b0;
        step();

        // Both cores finishing on the same edge.
        thread_count = 8'd8;
        start        = 1'b1;
        step(3);
        chk("both busy", int'(core_start), 3);
        core_done = 2'b11;
        step();
        chk("both clean", int'(core_reset), 3);
        core_done = 2'b00;
        step(2);
        chk("both done", int'(done), 1);
        start = 1'b0;
        step();

        foreach (vecs[k]) run_vec(vecs[k]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
